// File: rtl/muli_pipe.sv
// muli_pipe: elastic pipelined integer multiplier.
// Operands join on lhs/rhs valid. The selected product half enters stage 1,
// and stages 2..LATENCY retime it toward the result channel. Each stage has
// its own valid bit, so an empty slot always accepts and bubbles collapse.
module muli_pipe #(
  parameter int DATA_TYPE = 32,
  parameter int LATENCY   = 4,
  parameter int SIGNED    = 0,
  parameter int HIGH_HALF = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_TYPE-1:0] lhs,
  input  logic                 lhs_valid,
  input  logic [DATA_TYPE-1:0] rhs,
  input  logic                 rhs_valid,
  input  logic                 result_ready,
  output logic [DATA_TYPE-1:0] result,
  output logic                 result_valid,
  output logic                 lhs_ready,
  output logic                 rhs_ready
);

  localparam int PW = 2 * DATA_TYPE;

  logic [PW-1:0]        lhs_ext;
  logic [PW-1:0]        rhs_ext;
  logic [PW-1:0]        product;
  logic [DATA_TYPE-1:0] prod_sel;

  logic [LATENCY-1:0]   v;
  logic [LATENCY-1:0]   adv;
  logic [LATENCY-1:0]   in_v;
  logic [DATA_TYPE-1:0] d    [LATENCY];
  logic [DATA_TYPE-1:0] in_d [LATENCY];
  logic                 tail_full;
  logic                 fire;

  // Extend operands to full product width and select the requested half.
  always_comb begin
    if (SIGNED != 0) begin
      lhs_ext = {{DATA_TYPE{lhs[DATA_TYPE-1]}}, lhs};
      rhs_ext = {{DATA_TYPE{rhs[DATA_TYPE-1]}}, rhs};
    end else begin
      lhs_ext = {{DATA_TYPE{1'b0}}, lhs};
      rhs_ext = {{DATA_TYPE{1'b0}}, rhs};
    end
    product  = lhs_ext * rhs_ext;
    prod_sel = (HIGH_HALF != 0) ? product[PW-1:DATA_TYPE] : product[DATA_TYPE-1:0];
  end

  // Stage i advances unless it and every stage after it are full and the
  // sink is stalled; this is the unrolled form of the recursive stall chain.
  always_comb begin
    adv       = '0;
    tail_full = 1'b1;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      tail_full = 1'b1;
      for (int unsigned j = i; j < LATENCY; j++) begin
        tail_full = tail_full & v[j];
      end
      adv[i] = result_ready | ~tail_full;
    end
  end

  // Join: both operands must be present and stage 1 must be able to load.
  always_comb begin
    fire      = lhs_valid & rhs_valid & adv[0];
    lhs_ready = rhs_valid & adv[0];
    rhs_ready = lhs_valid & adv[0];
  end

  // Input of each stage: the join for stage 1, the previous stage otherwise.
  always_comb begin
    in_v    = '0;
    in_v[0] = fire;
    in_d[0] = prod_sel;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      in_v[i] = v[i-1];
      in_d[i] = d[i-1];
    end
  end

  // Stage registers; data moves only with a valid token to avoid toggling.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        d[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        if (adv[i]) begin
          v[i] <= in_v[i];
          if (in_v[i]) begin
            d[i] <= in_d[i];
          end
        end
      end
    end
  end

  assign result       = d[LATENCY-1];
  assign result_valid = v[LATENCY-1];

endmodule

// File: doc/muli_pipe.md
Name: muli_pipe

Overview:
- Parametrised successor to the fixed 4-stage integer multiplier.
- Elastic dataflow multiplier with configurable latency, signed/unsigned mode, and low- or high-half product selection.
- Per-stage valid bits let the pipeline collapse bubbles, so stages are not frozen by a single global clock-enable.
- Sits in the arith library as a drop-in handshake unit (join on two operands, one result channel) for the dataflow circuits.

Parameters:
- DATA_TYPE, 32, operand and result width in bits (>=1).
- LATENCY, 4, cycles from operand acceptance to result_valid (>=1).
- SIGNED, 0, 0 = unsigned operands, 1 = two's-complement operands.
- HIGH_HALF, 0, 0 = result is product bits [DATA_TYPE-1:0]; 1 = result is bits [2*DATA_TYPE-1:DATA_TYPE].

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- lhs  input  DATA_TYPE  left operand.
- lhs_valid  input  1  lhs valid.
- rhs  input  DATA_TYPE  right operand.
- rhs_valid  input  1  rhs valid.
- result_ready  input  1  downstream ready.
- result  output  DATA_TYPE  selected product half.
- result_valid  output  1  result valid.
- lhs_ready  output  1  lhs accepted this cycle when high together with lhs_valid.
- rhs_ready  output  1  rhs accepted this cycle when high together with rhs_valid.

Behaviour:
- Structure: stage registers S1..S_LATENCY, each holding valid v[i] and data d[i] (DATA_TYPE bits).
- Full 2*DATA_TYPE product is computed combinationally from lhs/rhs; the selected half is captured into S1. S2..S_LATENCY are retiming registers.
- Sign handling: SIGNED=1 sign-extends operands to 2*DATA_TYPE before multiplying; SIGNED=0 zero-extends. The low half is identical in both modes.
- Stall chain: adv[L] = result_ready or not v[L]; adv[i] = adv[i+1] or not v[i]. Stage i loads from stage i-1 (S1 loads from the join) exactly when adv[i] is high.
- On a load: v[i] <= v[i-1]. d[i] <= d[i-1] only when v[i-1]=1; data of empty slots is not propagated (power).
- Join: fire = lhs_valid and rhs_valid and adv[1].
  - lhs_ready = rhs_valid and adv[1]; rhs_ready = lhs_valid and adv[1].
  - A single valid operand is never consumed alone.
- Outputs: result = d[L], result_valid = v[L].
- Path: result_ready -> lhs_ready/rhs_ready is combinational through the adv chain. No combinational path from lhs_valid/rhs_valid to result_valid.
- Latency: a token accepted in cycle t shows result_valid in cycle t+LATENCY if no stall downstream.
- Throughput: one token per cycle with result_ready held high.
- Bubble collapse: an empty stage always accepts, even when result_ready=0. Up to LATENCY tokens can be held; with result_ready=0 the pipeline fills until v[1..L] are all 1, then lhs_ready and rhs_ready drop.
- Full pipe with result_ready=1: accept and emit in the same cycle (no bubble).
- Result stability: while result_valid=1 and result_ready=0, result and result_valid hold stable.
- Reset: synchronous, active-high. All v[i] <= 0 and all d[i] <= 0, so after reset result=0, result_valid=0, and lhs_ready/rhs_ready follow the opposite operand's valid (pipe empty).
  - Reset mid-operation discards all in-flight tokens; nothing emerges afterwards.
  - While rst=1 there are no handshakes; the ready outputs may be high but no state changes.
- Overflow: the product wraps modulo 2^DATA_TYPE in low-half mode. The high half is exact.
- LATENCY=1: the single stage register holds the product; the adv rule is unchanged.

Test Plan:
- DATA_TYPE=32, LATENCY=4, SIGNED=0, HIGH_HALF=0; lhs=7, rhs=6 valid at cycle 0, result_ready=1 -> result_valid=1 with result=42 at cycle 4 only.
- Streaming: 8 back-to-back pairs (i, i+1), i=0..7, result_ready=1 -> results 0,2,6,12,20,30,42,56 on consecutive cycles 4..11; ready held high throughout.
- Backpressure: result_ready=0, 6 pairs offered -> exactly 4 accepted, then lhs_ready=rhs_ready=0. Raise result_ready -> 4 results in order, then the remaining 2 accepted and emitted; result stable while stalled.
- Join and bubbles: lhs_valid=1 alone for 3 cycles -> lhs_ready=0 and no token. Then rhs_valid=1 -> single accept. Insert a gap of 2 cycles between pairs with result_ready=0 -> tokens pack into adjacent stages.
- Mode: DATA_TYPE=8, SIGNED=1, HIGH_HALF=1, lhs=8'hFF (-1), rhs=8'h02 -> result=8'hFF. With SIGNED=0 -> result=8'h01. With HIGH_HALF=0 -> result=8'hFE in both modes.
- Reset mid-flight: 3 tokens in pipe, assert rst for 1 cycle -> result_valid=0 next cycle, result=0, no stale result ever appears; the next accepted pair completes with normal latency.
